// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin share of one Clause-22 MDIO master.
// Build option MDIO_ARB_TIMEOUT_EN adds a read timeout that raises rsp_err.
module mdio_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int START_CYC   = 2,
  parameter int WR_CYCLES   = 140,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [5*NUM_REQ-1:0]  req_phy,
  input  logic [5*NUM_REQ-1:0]  req_reg,
  input  logic [16*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  m_reset_n,
  output logic                  m_start,
  output logic [31:0]           m_t_data,
  input  logic                  m_data_rdy,
  input  logic [15:0]           m_rd_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_WR,
    S_WAIT_RD,
    S_RESP
  } state_e;

  state_e              state_q;
  logic [IW-1:0]       last_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [15:0]         rsp_data_q;
  logic                m_reset_n_q;
  logic                m_start_q;
  logic [31:0]         t_data_q;
  logic                we_q;
  logic                prev_q;
  logic [CW-1:0]       cnt_q;

  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  int                  j;
  logic [31:0]         frm_a [NUM_REQ];

  // Scan from the farthest offset down so the nearest one after last wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(last_q) + i) % NUM_REQ;
      if (req[IW'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      frm_a[k] = {2'b01,
                  req_we[k] ? 2'b01 : 2'b10,
                  req_phy[5*k +: 5],
                  req_reg[5*k +: 5],
                  2'b10,
                  req_we[k] ? req_wdata[16*k +: 16] : 16'h0000};
    end
  end

`ifdef MDIO_ARB_TIMEOUT_EN
  logic rsp_err_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(NUM_REQ-1);
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      m_reset_n_q <= 1'b0;
      m_start_q   <= 1'b0;
      t_data_q    <= '0;
      we_q        <= 1'b0;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          m_reset_n_q <= 1'b1;
          if (pick_vld) begin
            grant_q     <= NUM_REQ'(1) << pick_idx;
            last_q      <= pick_idx;
            we_q        <= req_we[pick_idx];
            t_data_q    <= frm_a[pick_idx];
            m_reset_n_q <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          m_reset_n_q <= 1'b1;
          m_start_q   <= 1'b1;
          prev_q      <= 1'b1;
          cnt_q       <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
          rsp_err_q   <= 1'b0;
`endif
          state_q     <= S_START;
        end
        S_START: begin
          if (cnt_q == CW'(START_CYC-1)) begin
            m_start_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= we_q ? S_WAIT_WR : S_WAIT_RD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_WR: begin
          if (cnt_q == CW'(WR_CYCLES-1)) begin
            rsp_valid_q <= grant_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_RD: begin
          prev_q <= m_data_rdy;
          if (m_data_rdy && !prev_q) begin
            rsp_data_q  <= m_rd_data;
            rsp_valid_q <= grant_q;
            state_q     <= S_RESP;
`ifdef MDIO_ARB_TIMEOUT_EN
          end else if (cnt_q == CW'(TIMEOUT_CYC-1)) begin
            rsp_data_q  <= 16'hFFFF;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= grant_q;
            state_q     <= S_RESP;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);
  assign m_reset_n = m_reset_n_q;
  assign m_start   = m_start_q;
  assign m_t_data  = t_data_q;
`ifdef MDIO_ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
